// File: rtl/reg_file_mp.sv
// Dual-write, dual-read register file with a swept clear engine.
// Ports: RA/RB->Bus_A/Bus_B reads, RW*/Bus_W*/reg_write* writes, clear_req/busy/ready.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] Bus_A,
  output logic [DATA_W-1:0] Bus_B,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] Bus_W0,
  input  logic [DATA_W-1:0] Bus_W1,
  input  logic              reg_write0,
  input  logic              reg_write1,
  input  logic              clear_req,
  output logic              busy,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic we0, we1;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign busy  = (state_q == CLEAR);
  assign ready = ~busy;

  // Reset parks the FSM in CLEAR so the array is swept after every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Port 0 is dropped on an address collision so port 1 wins outright.
  always_comb begin
    we0 = ready & reg_write0;
    we1 = ready & reg_write1;
    if (ZERO_REG && RW0 == '0) we0 = 1'b0;
    if (ZERO_REG && RW1 == '0) we1 = 1'b0;
    if (we1 && RW1 == RW0) we0 = 1'b0;
  end

  // Storage has no reset; the sweep is the only zeroing path.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (we0) mem_q[RW0] <= Bus_W0;
        if (we1) mem_q[RW1] <= Bus_W1;
      end
    end
  end

  always_comb begin
    rd_a = mem_q[RA];
    rd_b = mem_q[RB];
    if (BYPASS) begin
      if (we0 && RW0 == RA) rd_a = Bus_W0;
      if (we1 && RW1 == RA) rd_a = Bus_W1;
      if (we0 && RW0 == RB) rd_b = Bus_W0;
      if (we1 && RW1 == RB) rd_b = Bus_W1;
    end
    if (busy || (ZERO_REG && RA == '0)) rd_a = '0;
    if (busy || (ZERO_REG && RB == '0)) rd_b = '0;
  end

  assign Bus_A = rd_a;
  assign Bus_B = rd_b;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: bypassing and non-bypassing instances
// share stimulus; expectations are queued and checked on the falling edge.
module tb_reg_file_mp;

  localparam int K_BUSY  = 0;
  localparam int K_READY = 1;
  localparam int K_A     = 2;
  localparam int K_B     = 3;
  localparam int K_A_NB  = 4;
  localparam int K_B_NB  = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra, rb, rw0, rw1;
  logic [31:0] w0, w1;
  logic        we0, we1, clr;
  logic [31:0] a_b, b_b, a_n, b_n;
  logic        busy_b, ready_b, busy_n, ready_n;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_file_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .RA(ra), .RB(rb), .Bus_A(a_b), .Bus_B(b_b),
    .RW0(rw0), .RW1(rw1), .Bus_W0(w0), .Bus_W1(w1),
    .reg_write0(we0), .reg_write1(we1),
    .clear_req(clr), .busy(busy_b), .ready(ready_b)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .RA(ra), .RB(rb), .Bus_A(a_n), .Bus_B(b_n),
    .RW0(rw0), .RW1(rw1), .Bus_W0(w0), .Bus_W1(w1),
    .reg_write0(we0), .reg_write1(we1),
    .clear_req(clr), .busy(busy_n), .ready(ready_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_BUSY:  act = {31'b0, busy_b};
        K_READY: act = {31'b0, ready_b};
        K_A:     act = a_b;
        K_B:     act = b_b;
        K_A_NB:  act = a_n;
        default: act = b_n;
      endcase
      if (e.kind == K_BUSY && busy_n !== busy_b) begin
        n_bad++;
        $display("FAIL %s busy_nob: got %b want %b", e.name, busy_n, busy_b);
      end
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic exp(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0;
    we1 = 1'b0;
    clr = 1'b0;
  endtask

  // Busy for 32 observed cycles, then ready, while hammering writes.
  task automatic sweep_watch(input string tag);
    for (int k = 0; k < 32; k++) begin
      ra  = 5'd3;
      rb  = 5'd3;
      rw0 = 5'd3;
      w0  = 32'h0000ABCD;
      we0 = 1'b1;
      clr = (k % 5 == 2);
      exp({tag, "_busy"}, K_BUSY, 32'd1);
      exp({tag, "_a"}, K_A, 32'd0);
      exp({tag, "_a_nb"}, K_A_NB, 32'd0);
      cyc();
    end
    idle_in();
    exp({tag, "_done_busy"}, K_BUSY, 32'd0);
    exp({tag, "_done_ready"}, K_READY, 32'd1);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      cyc();
      ra = 5'(i);
      rb = 5'(31 - i);
      exp({tag, "_a"}, K_A, 32'd0);
      exp({tag, "_b_nb"}, K_B_NB, 32'd0);
    end
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i += 2) begin
      cyc();
      rw0 = 5'(i);
      w0  = 32'(i);
      we0 = 1'b1;
      rw1 = 5'(i + 1);
      w1  = 32'(i + 1);
      we1 = (i < 31);
    end
    cyc();
    idle_in();
  endtask

  initial begin
    rst_n = 1'b0;
    ra = '0; rb = '0; rw0 = '0; rw1 = '0;
    w0 = '0; w1 = '0;
    idle_in();

    // Reset held three cycles: busy immediately, reads forced to 0.
    #1;
    exp("rst_busy", K_BUSY, 32'd1);
    exp("rst_ready", K_READY, 32'd0);
    exp("rst_a", K_A, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp("rst_hold_busy", K_BUSY, 32'd1);
    end
    rst_n = 1'b1;
    sweep_watch("rst_sweep");
    all_zero("post_rst");

    // Collision: port 1 wins, bypass shows port 1 in the same cycle.
    cyc();
    ra = 5'd7; rb = 5'd7;
    rw0 = 5'd7; w0 = 32'h11111111; we0 = 1'b1;
    rw1 = 5'd7; w1 = 32'h22222222; we1 = 1'b1;
    exp("coll_byp_a", K_A, 32'h22222222);
    exp("coll_nob_a", K_A_NB, 32'd0);
    cyc();
    idle_in();
    exp("coll_after_a", K_A, 32'h22222222);
    exp("coll_after_a_nb", K_A_NB, 32'h22222222);

    // Bypass vs stored data on port 0.
    cyc();
    ra = 5'd5; rb = 5'd7;
    rw0 = 5'd5; w0 = 32'hDEADBEEF; we0 = 1'b1;
    exp("byp_a", K_A, 32'hDEADBEEF);
    exp("byp_nob_a", K_A_NB, 32'd0);
    exp("byp_b", K_B, 32'h22222222);
    cyc();
    idle_in();
    exp("byp_after_a", K_A, 32'hDEADBEEF);
    exp("byp_after_a_nb", K_A_NB, 32'hDEADBEEF);

    // Zero register ignores writes on both ports, even via bypass.
    cyc();
    ra = 5'd0; rb = 5'd0;
    rw0 = 5'd0; w0 = 32'hFFFFFFFF; we0 = 1'b1;
    rw1 = 5'd0; w1 = 32'hFFFFFFFF; we1 = 1'b1;
    exp("zero_during_a", K_A, 32'd0);
    exp("zero_during_b", K_B, 32'd0);
    cyc();
    idle_in();
    exp("zero_after_a", K_A, 32'd0);
    exp("zero_after_a_nb", K_A_NB, 32'd0);

    // Fill 1..31 with index and read back.
    fill();
    for (int i = 1; i < 32; i++) begin
      cyc();
      ra = 5'(i);
      rb = 5'(32 - i);
      exp("fill_a", K_A, 32'(i));
      exp("fill_b_nb", K_B_NB, 32'(32 - i));
    end

    // Clear request; a write in the same cycle still lands.
    cyc();
    clr = 1'b1;
    ra = 5'd31;
    rw0 = 5'd31; w0 = 32'h55; we0 = 1'b1;
    exp("clr_req_busy", K_BUSY, 32'd0);
    exp("clr_req_byp", K_A, 32'h55);
    exp("clr_req_nob", K_A_NB, 32'd31);
    cyc();
    sweep_watch("clr_sweep");
    all_zero("post_clr");

    // Reset asserted with the counter at 10 restarts the sweep.
    fill();
    cyc();
    clr = 1'b1;
    exp("mid_req_busy", K_BUSY, 32'd0);
    cyc();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      exp("mid_run_busy", K_BUSY, 32'd1);
      cyc();
    end
    rst_n = 1'b0;
    exp("mid_rst_busy", K_BUSY, 32'd1);
    exp("mid_rst_ready", K_READY, 32'd0);
    cyc();
    exp("mid_rst_hold", K_BUSY, 32'd1);
    cyc();
    rst_n = 1'b1;
    sweep_watch("mid_sweep");
    all_zero("post_mid");

    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding when 1.
REQ-005 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RA, RB  in  ADDR_W  read addresses, ports A/B.
- Bus_A, Bus_B  out  DATA_W  read data, ports A/B.
- RW0, RW1  in  ADDR_W  write addresses, ports 0/1.
- Bus_W0, Bus_W1  in  DATA_W  write data, ports 0/1.
- reg_write0, reg_write1  in  1  write enables, ports 0/1.
- clear_req  in  1  one-cycle request to zero the whole file.
- busy  out  1  high while a clear sweep runs.
- ready  out  1  equals ~busy.

Function
REQ-006 Reads SHALL be combinational from RA/RB to Bus_A/Bus_B, with zero added latency.
REQ-007 When ready=1, each write port SHALL update entry RWn with Bus_Wn on the rising clk edge where reg_writen=1.
REQ-008 When both write ports are enabled with RW0==RW1, port 1 SHALL win and port 0 SHALL be dropped.
REQ-009 When ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0 regardless of bypass.
REQ-010 When BYPASS=1 and ready=1, a read whose address matches an enabled write port in the same cycle SHALL return that port's Bus_Wn, with port 1 taking precedence over port 0.
REQ-011 When BYPASS=0, reads SHALL return stored contents only, i.e. pre-edge data.
REQ-012 The control FSM SHALL have exactly two states, IDLE (busy=0) and CLEAR (busy=1).
REQ-013 The FSM SHALL contain a clear counter ADDR_W bits wide.
REQ-014 In CLEAR, each clk edge SHALL write 0 to the entry at the counter and then increment the counter.
REQ-015 When the counter equals DEPTH-1, the FSM SHALL write that entry and return to IDLE on the same edge.
REQ-016 A full clear sweep SHALL therefore take exactly DEPTH cycles.
REQ-017 In IDLE, clear_req=1 at an edge SHALL set the counter to 0 and enter CLEAR, with busy=1 from the next cycle.
REQ-018 Writes presented in the same cycle as a clear_req in IDLE SHALL still be performed.
REQ-019 While busy=1, reg_write0/1 SHALL be ignored, Bus_A/Bus_B SHALL read 0, and clear_req SHALL be ignored, with no restart.
REQ-020 The counter SHALL NOT wrap: the transition to IDLE at DEPTH-1 is the only exit from CLEAR.
REQ-021 Array storage SHALL have no per-entry reset; zeroing SHALL be done only by the sweep.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without a clock edge, force the FSM to CLEAR, set the counter to 0, drive busy=1 and ready=0, and drive Bus_A/Bus_B to 0.
REQ-023 While rst_n=0, no array writes SHALL occur.
REQ-024 After rst_n deasserts, the sweep SHALL start on the first clk edge and busy SHALL fall after DEPTH edges.
REQ-025 Reset asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-026 Reset asserted mid-operation in IDLE SHALL discard any write in flight at that edge.

Verification
REQ-027 The bench SHALL cover the reset sweep: rst_n low for 3 cycles, then high -> busy=1 for exactly 32 edges, then ready=1 and every RA read returns 0.
REQ-028 The bench SHALL cover dual-write collision: RW0=RW1=7, Bus_W0=0x11111111, Bus_W1=0x22222222, both enables high -> after the edge, RA=7 reads 0x22222222.
REQ-029 The bench SHALL cover bypass: with BYPASS=1, RA=5, RW0=5, Bus_W0=0xDEADBEEF, reg_write0=1 -> Bus_A=0xDEADBEEF in the same cycle; with BYPASS=0 -> Bus_A holds the old value until the edge.
REQ-030 The bench SHALL cover the zero register: write 0xFFFFFFFF to address 0 on both ports -> Bus_A with RA=0 reads 0 during and after the write.
REQ-031 The bench SHALL cover clear with blocked writes: fill entries 1..31 with their own index, pulse clear_req, attempt a write of 0xABCD to RW0=3 during busy -> after 32 cycles, all entries read 0 and entry 3 is not 0xABCD.
REQ-032 The bench SHALL cover reset mid-sweep: assert rst_n=0 at counter=10 -> busy stays 1 and ready rises exactly 32 edges after rst_n deasserts.
